// File: rtl/display_pkg.sv
// Shared encodings for the 7-segment scan controller: FSM states,
// digit count and anode/digit-select idle patterns.
package display_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;

  localparam int         NUM_DIGITS = 4;
  localparam int         IDX_W      = $clog2(NUM_DIGITS);
  localparam logic [3:0] ANODES_OFF = 4'b1111;
  localparam logic [3:0] DIG_RESET  = 4'b0001;

  function automatic logic [3:0] idx_to_dig(input logic [IDX_W-1:0] i);
    return DIG_RESET << i;
  endfunction
endpackage

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 4-digit anode scanner with blanking gaps and a
// frame-synchronous double buffer for the displayed BCD value.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CNT_W        = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] number_in,
  input  logic        number_load,
  output logic [15:0] number,
  output logic [3:0]  dig,
  output logic [3:0]  an_n,
  output logic        frame_done,
  output logic        load_pending
);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [3:0]       dig_nx, an_nx;
  logic [15:0]      staging, staging_nx, number_nx;
  logic             fd_nx, pend_nx, frame_end, commit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      idx          <= '0;
      dig          <= DIG_RESET;
      an_n         <= ANODES_OFF;
      frame_done   <= 1'b0;
      number       <= '0;
      staging      <= '0;
      load_pending <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      idx          <= idx_nx;
      dig          <= dig_nx;
      an_n         <= an_nx;
      frame_done   <= fd_nx;
      number       <= number_nx;
      staging      <= staging_nx;
      load_pending <= pend_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    idx_nx     = idx;
    dig_nx     = dig;
    an_nx      = an_n;
    fd_nx      = 1'b0;
    frame_end  = 1'b0;
    number_nx  = number;
    staging_nx = staging;
    pend_nx    = load_pending;

    case (state)
      ST_IDLE: begin
        an_nx  = ANODES_OFF;
        dig_nx = DIG_RESET;
        idx_nx = '0;
        cnt_nx = '0;
        if (enable) begin
          if (BLANK_CYCLES == 0) begin
            state_nx = ST_SHOW;
            an_nx    = ~DIG_RESET;
          end else begin
            state_nx = ST_BLANK;
          end
        end
      end
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nx = ST_SHOW;
          cnt_nx   = '0;
          an_nx    = ~dig;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_SHOW: begin
        if (cnt == SHOW_LAST) begin
          // dig moves to the next digit here so the decoder settles during BLANK
          cnt_nx    = '0;
          idx_nx    = idx + IDX_W'(1);
          dig_nx    = idx_to_dig(idx + IDX_W'(1));
          frame_end = (idx == IDX_LAST);
          fd_nx     = frame_end;
          if (BLANK_CYCLES == 0) begin
            an_nx = ~idx_to_dig(idx + IDX_W'(1));
          end else begin
            state_nx = ST_BLANK;
            an_nx    = ANODES_OFF;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    if (!enable) begin
      state_nx  = ST_IDLE;
      cnt_nx    = '0;
      idx_nx    = '0;
      dig_nx    = DIG_RESET;
      an_nx     = ANODES_OFF;
      fd_nx     = 1'b0;
      frame_end = 1'b0;
    end

    // A load coinciding with a commit bypasses staging straight to the display
    commit = (state == ST_IDLE) || frame_end;
    if (commit) begin
      if (number_load) begin
        number_nx  = number_in;
        staging_nx = number_in;
        pend_nx    = 1'b0;
      end else if (load_pending) begin
        number_nx = staging;
        pend_nx   = 1'b0;
      end
    end else if (number_load) begin
      staging_nx = number_in;
      pend_nx    = 1'b1;
    end
  end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed + random bench: two scanners (with and without blanking) checked
// every cycle against a time-since-enable arithmetic model.
module tb_display_scan_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, number_load = 1'b0;
  logic [15:0] number_in = '0;
  logic [15:0] num0, num1;
  logic [3:0]  dig0, dig1, an0, an1;
  logic        fd0, fd1, lp0, lp1;
  int          total = 0, bad = 0;

  // model state per instance: 0 = BLANK_CYCLES 2, 1 = BLANK_CYCLES 0
  int          m_run[2], m_t[2], m_fe[2], m_pend[2];
  logic [15:0] m_num[2], m_stg[2];

  display_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYCLES(2), .CNT_W(20)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .number_in(number_in),
    .number_load(number_load), .number(num0), .dig(dig0), .an_n(an0),
    .frame_done(fd0), .load_pending(lp0));

  display_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYCLES(0), .CNT_W(20)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .number_in(number_in),
    .number_load(number_load), .number(num1), .dig(dig1), .an_n(an1),
    .frame_done(fd1), .load_pending(lp1));

  always #5 clk = ~clk;

  function automatic int blank_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int p;
      bit idle_before, commit;
      p = 4 * (blank_of(k) + 8);
      m_fe[k] = 0;
      if (!rst_n) begin
        m_run[k] = 0; m_t[k] = 0; m_num[k] = '0; m_stg[k] = '0; m_pend[k] = 0;
      end else begin
        idle_before = (m_run[k] == 0);
        if (enable) begin
          if (m_run[k] != 0) m_t[k]++;
          else begin m_run[k] = 1; m_t[k] = 0; end
          m_fe[k] = (m_t[k] > 0 && m_t[k] % p == 0) ? 1 : 0;
        end else begin
          m_run[k] = 0;
        end
        commit = idle_before || (m_fe[k] != 0);
        if (commit) begin
          if (number_load) begin
            m_num[k] = number_in; m_stg[k] = number_in; m_pend[k] = 0;
          end else if (m_pend[k] != 0) begin
            m_num[k] = m_stg[k]; m_pend[k] = 0;
          end
        end else if (number_load) begin
          m_stg[k] = number_in; m_pend[k] = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic [3:0] ea, ed;
      int b, p, d, r;
      b = blank_of(k);
      if (m_run[k] == 0) begin
        ea = 4'hF; ed = 4'h1;
      end else begin
        p  = m_t[k] % (4 * (b + 8));
        d  = p / (b + 8);
        r  = p % (b + 8);
        ed = 4'(1 << d);
        ea = (r < b) ? 4'hF : ~ed;
      end
      chk("an_n",   k, 16'(k == 0 ? an0  : an1),  16'(ea));
      chk("dig",    k, 16'(k == 0 ? dig0 : dig1), 16'(ed));
      chk("frame",  k, 16'(k == 0 ? fd0  : fd1),  16'(m_fe[k]));
      chk("number", k, k == 0 ? num0 : num1, m_num[k]);
      chk("pend",   k, 16'(k == 0 ? lp0  : lp1),  16'(m_pend[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    number_load = 1'b0;
  endtask

  task automatic load(input logic [15:0] v);
    number_in   = v;
    number_load = 1'b1;
    step();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_t[k] = 0; m_fe[k] = 0; m_pend[k] = 0; m_num[k] = '0; m_stg[k] = '0;
    end
    // reset state
    step(); step();
    rst_n = 1'b1;
    step();
    // steady scanning
    enable = 1'b1;
    repeat (60) step();
    // load during digit 1, commit at frame boundary
    while (m_t[0] % 40 != 15) step();
    load(16'h1234);
    repeat (40) step();
    // two loads in one frame, last wins
    while (m_t[0] % 40 != 5) step();
    load(16'h1111);
    repeat (10) step();
    load(16'h2222);
    repeat (40) step();
    // load on the exact frame_done edge
    while (m_t[0] % 40 != 39) step();
    load(16'h5678);
    repeat (5) step();
    // enable dropped during digit 2 SHOW with pending data
    while (m_t[0] % 40 != 25) step();
    load(16'h9999);
    enable = 1'b0;
    repeat (3) step();
    enable = 1'b1;
    repeat (15) step();
    // reset mid-SHOW with a coincident load
    while (m_t[0] % 40 != 5) step();
    rst_n = 1'b0;
    number_in = 16'hABCD;
    number_load = 1'b1;
    step();
    rst_n = 1'b1;
    repeat (20) step();
    // random traffic
    repeat (1500) begin
      if ($urandom_range(11) == 0) begin
        number_in   = 16'($urandom);
        number_load = 1'b1;
      end
      if ($urandom_range(199) == 0) enable = ~enable;
      if ($urandom_range(499) == 0) rst_n = 1'b0;
      step();
      rst_n = 1'b1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexing controller for the 4-digit common-anode 7-segment indicator. It rotates a one-hot digit select through the four digits at a programmable rate, inserting a blanking gap between digits to prevent ghosting. It double-buffers the 16-bit BCD value arriving from the UART side so that the displayed value changes only at frame boundaries. It sits between the UART receive path and the combinational segment decoder, driving the decoder's number/dig inputs and the anode lines.

Parameters:
SCAN_DIV, 50000, clock cycles each digit is lit (SHOW phase); legal range 1..2^20-1
BLANK_CYCLES, 500, clock cycles all anodes are off before each digit (BLANK phase); 0 = no blanking
CNT_W, 20, width of the phase counter; must hold max(SCAN_DIV, BLANK_CYCLES)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active-low
enable  input  1  1 = scan running; 0 = display dark
number_in  input  16  four BCD digits from UART side; [3:0] is digit 0
number_load  input  1  single-cycle strobe; capture number_in into staging
number  output  16  committed value, feeds the decoder number input
dig  output  4  one-hot digit select, feeds the decoder dig input; bit0 = digit 0
an_n  output  4  anode drive, active-low; 1111 = all off
frame_done  output  1  one-cycle pulse at the end of the digit-3 SHOW phase
load_pending  output  1  staging holds a value not yet committed

Behaviour:
- All outputs registered. Reset (rst_n=0 at clk edge): number=0, dig=0001, an_n=1111, frame_done=0, load_pending=0, staging=0, digit index=0, counter=0, state=IDLE.
- FSM states: IDLE, BLANK, SHOW.
- IDLE: an_n=1111, dig=0001. When enable=1, go to BLANK, or directly to SHOW if BLANK_CYCLES=0. Counter cleared.
- BLANK: an_n=1111. dig already reflects the upcoming digit, so the decoder settles while the display is dark. Lasts exactly BLANK_CYCLES cycles, then SHOW.
- SHOW: an_n = ~dig. Lasts exactly SCAN_DIV cycles. At the end:
  - Advance the index (3 wraps to 0) and update dig on the same edge, then go to BLANK (or SHOW if BLANK_CYCLES=0).
  - If the index was 3, assert frame_done for that one cycle (the edge leaving SHOW).
- Frame period = 4*(BLANK_CYCLES+SCAN_DIV) cycles. In steady state exactly one an_n bit is low, or none.
- Load handling:
  - number_load=1 copies number_in to staging and sets load_pending=1.
  - A later load before commit overwrites staging; last value wins.
- Commit happens on the frame_done edge, and on any cycle in IDLE:
  - If load_pending=1, number<=staging and load_pending<=0.
  - If number_load coincides with a commit edge, number_in is committed directly, staging<=number_in, and load_pending=0.
- enable dropped mid-frame: the next edge goes to IDLE, an_n=1111, index=0, dig=0001. No frame_done. Pending data is then committed while in IDLE.
- enable re-asserted: scan restarts at digit 0 with a full BLANK phase.
- Reset mid-operation overrides everything on that edge, including a coincident number_load.
- The counter never exceeds the current phase length minus 1; there is no free-running wrap.

Decomposition:
- Shared package (display_pkg): state encoding localparams (ST_IDLE, ST_BLANK, ST_SHOW), NUM_DIGITS=4, ANODES_OFF=4'b1111, DIG_RESET=4'b0001.
- No sub-module. The counter and FSM are small enough to live in one module.
- The segment decoder is instantiated at the top level, not inside this block.

Test Plan:
(SCAN_DIV=8, BLANK_CYCLES=2 unless noted)
- Reset, then enable=1 -> an_n=1111 for 2 cycles; then an_n=1110 for 8 cycles; then 1111 for 2; then 1101 for 8, and so on. The 1110 phase recurs every 40 cycles. frame_done pulses once per 40 cycles, on the edge leaving the 0111 phase.
- number_load with 0x1234 mid-frame (during digit 1) -> load_pending=1; number stays 0x0000 until the frame_done edge, then becomes 0x1234 and load_pending=0.
- Two loads in one frame (0x1111, then 0x2222) -> only 0x2222 is committed at the frame boundary; 0x1111 never appears on number.
- number_load with 0x5678 on the exact frame_done edge -> number=0x5678 on that edge; load_pending stays 0.
- enable dropped during digit 2 SHOW -> next cycle an_n=1111, dig=0001, no frame_done. A pending 0x9999 commits in IDLE. Re-enable gives 2 BLANK cycles, then an_n=1110.
- BLANK_CYCLES=0 -> an_n goes 1110, 1101, 1011, 0111, 8 cycles each, with no gap and never 1111 after start. rst_n=0 for one cycle mid-SHOW -> all outputs return to reset values on that edge.
